// File: rtl/uart_lb_pkg.sv
// Shared types and constants for the buffered UART loopback: baud codes,
// drain FSM states, statistics width and the baud-code to bit-divisor helper.
package uart_lb_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int STAT_W = 16;
  localparam int DIV_W  = 16;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} lb_state_t;

  // Clock cycles per serial bit; unknown codes fall back to 115200.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code, input int clk_hz);
    int rate;
    case (code)
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      BAUD_38400: rate = 38400;
      BAUD_57600: rate = 57600;
      default:    rate = 115200;
    endcase
    return DIV_W'(clk_hz / rate);
  endfunction

endpackage

// File: rtl/lb_word_fifo.sv
// Synchronous word FIFO with registered occupancy; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module lb_word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_data_rx.sv
// Multi-byte UART receiver: 8N1 bytes assembled into a DATA_WIDTH word, rx_done
// pulses with the complete word; timeout pulses if a partial word stalls 16 bit times.
module uart_data_rx #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 0,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIV_W-1:0]      bit_div,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  rx_done,
  output logic                  timeout
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int BN_W = $clog2(NB + 1);
  localparam int TO_W = DIV_W + 4;

  logic [1:0]       sync;
  logic             rx_s;
  logic             busy;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       sh;
  logic [BN_W-1:0]  nbyte;
  logic [BN_W-1:0]  slot;
  logic [TO_W-1:0]  idle_cnt;

  assign rx_s = sync[1];
  assign slot = MSB_FIRST ? (BN_W'(NB - 1) - nbyte) : nbyte;

  // bit_idx 0 = start-bit check at mid-bit, 1..8 = data, 9 = stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= 2'b11;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      nbyte    <= '0;
      idle_cnt <= '0;
      data     <= '0;
      rx_done  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      sync    <= {sync[0], uart_rx};
      rx_done <= 1'b0;
      timeout <= 1'b0;
      if (!busy) begin
        if (!rx_s) begin
          busy     <= 1'b1;
          cnt      <= (bit_div >> 1) - 1'b1;
          bit_idx  <= '0;
          idle_cnt <= '0;
        end else if (nbyte != '0) begin
          if (idle_cnt == {bit_div, 4'b0000}) begin
            timeout  <= 1'b1;
            nbyte    <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= bit_div - 1'b1;
        if (bit_idx == 4'd0) begin
          if (rx_s) busy <= 1'b0;
          else      bit_idx <= 4'd1;
        end else if (bit_idx != 4'd9) begin
          sh      <= {rx_s, sh[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end else begin
          busy <= 1'b0;
          if (rx_s) begin
            data[slot*8 +: 8] <= sh;
            if (nbyte == BN_W'(NB - 1)) begin
              nbyte   <= '0;
              rx_done <= 1'b1;
            end else begin
              nbyte <= nbyte + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_data_tx.sv
// Multi-byte UART transmitter: send_en latches a DATA_WIDTH word and shifts it
// out as DATA_WIDTH/8 back-to-back 8N1 frames; tx_done pulses after the last stop bit.
module uart_data_tx #(
  parameter int DATA_WIDTH = 32,
  parameter bit MSB_FIRST  = 0,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DIV_W-1:0]      bit_div,
  input  logic                  send_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  uart_tx,
  output logic                  tx_done,
  output logic                  busy
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int FB   = NB * 10;
  localparam int BC_W = $clog2(FB + 1);

  logic [FB-1:0]    frame;
  logic [FB-1:0]    sh;
  logic [DIV_W-1:0] cnt;
  logic [BC_W-1:0]  nbits;

  // Whole word pre-framed so that shifting right emits start, data LSB first, stop.
  always_comb begin
    frame = '1;
    for (int k = 0; k < NB; k++) begin
      frame[k*10 +: 10] = {1'b1, data[(MSB_FIRST ? (NB - 1 - k) : k)*8 +: 8], 1'b0};
    end
  end

  assign uart_tx = sh[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh      <= '1;
      busy    <= 1'b0;
      cnt     <= '0;
      nbits   <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!busy) begin
        if (send_en) begin
          sh    <= frame;
          busy  <= 1'b1;
          cnt   <= bit_div - 1'b1;
          nbits <= BC_W'(FB - 1);
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (nbits == '0) begin
        busy    <= 1'b0;
        tx_done <= 1'b1;
        sh      <= '1;
      end else begin
        sh    <= {1'b1, sh[FB-1:1]};
        nbits <= nbits - 1'b1;
        cnt   <= bit_div - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_loopback_buf.sv
// Buffered UART loopback: received words queue in a FIFO and a drain FSM replays
// them on uart_tx. Define UART_LOOPBACK_STATS_EN to add rx_count/tx_count ports.
module uart_loopback_buf
  import uart_lb_pkg::*;
#(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         DATA_WIDTH   = 32,
  parameter bit         MSB_FIRST    = 0,
  parameter int         DEPTH        = 8,
  parameter int         GAP_CYCLES   = 0,
  parameter logic [2:0] BAUD_DEFAULT = BAUD_115200
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   uart_rx,
  input  logic [2:0]             baud_set,
  input  logic                   loop_en,
  input  logic                   clr_flags,
  output logic                   uart_tx,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [3:0]             flag,
`ifdef UART_LOOPBACK_STATS_EN
  output logic [STAT_W-1:0]      rx_count,
  output logic [STAT_W-1:0]      tx_count,
`endif
  output lb_state_t              state_dbg
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  lb_state_t             state;
  logic [2:0]            baud_q;
  logic [DIV_W-1:0]      bit_div;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_done;
  logic                  rx_timeout;
  logic                  tx_done;
  logic                  tx_busy;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push_acc;
  logic                  ovf;
  logic                  send_en;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [GAP_W-1:0]      gap_cnt;

  assign bit_div   = baud_div(baud_q, CLK_HZ);
  assign pop       = (state == LOAD);
  assign push_acc  = rx_done && (!full || pop);
  assign flag      = {ovf, tx_busy, tx_done, rx_timeout};
  assign state_dbg = state;

  uart_data_rx #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST), .DIV_W(DIV_W)) u_rx (
    .clk(clk), .reset_n(reset_n), .bit_div(bit_div), .uart_rx(uart_rx),
    .data(rx_data), .rx_done(rx_done), .timeout(rx_timeout)
  );

  lb_word_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_done), .wdata(rx_data), .pop(pop),
    .rdata(fifo_rdata), .full(full), .empty(empty), .level(fifo_level)
  );

  uart_data_tx #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST), .DIV_W(DIV_W)) u_tx (
    .clk(clk), .reset_n(reset_n), .bit_div(bit_div), .send_en(send_en), .data(tx_word),
    .uart_tx(uart_tx), .tx_done(tx_done), .busy(tx_busy)
  );

  // Baud only moves while nothing is queued or in flight, so no word straddles a rate change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      send_en <= 1'b0;
      tx_word <= '0;
      gap_cnt <= '0;
      baud_q  <= BAUD_DEFAULT;
    end else begin
      send_en <= 1'b0;
      if (state == IDLE && empty) baud_q <= baud_set;
      case (state)
        IDLE: if (!empty && loop_en) state <= LOAD;
        LOAD: begin
          tx_word <= fifo_rdata;
          send_en <= 1'b1;
          state   <= SEND;
        end
        SEND: state <= WAIT;
        WAIT: if (tx_done) begin
          if (GAP_CYCLES > 0) begin
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            state   <= GAP;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear beats a same-cycle overflow so software never loses a pending clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      ovf <= 1'b0;
    else if (clr_flags)                ovf <= 1'b0;
    else if (rx_done && full && !pop)  ovf <= 1'b1;
  end

`ifdef UART_LOOPBACK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_count <= '0;
      tx_count <= '0;
    end else if (clr_flags) begin
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      if (push_acc && rx_count != '1) rx_count <= rx_count + 1'b1;
      if (tx_done && tx_count != '1)  tx_count <= tx_count + 1'b1;
    end
  end
`else
  logic unused_push_acc;
  assign unused_push_acc = push_acc;
`endif

endmodule
